// File: rtl/conv_tile_scheduler.sv
// Tile scheduler for the 16-MAC 3x3 convolution array: walks (x, y, group) in raster order,
// fetches operands, fires the array, and hands each result to the output writer.
module conv_tile_scheduler #(
   parameter int NUM_MACS = 16,
   parameter int DIM_BITS = 8,
   parameter int GRP_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DIM_BITS-1:0] cfg_out_w,
   input  logic [DIM_BITS-1:0] cfg_out_h,
   input  logic [GRP_BITS-1:0] cfg_groups,
   input  logic                cfg_mode,
   output logic                busy,
   output logic                done,
   output logic                fetch_req,
   output logic [DIM_BITS-1:0] fetch_x,
   output logic [DIM_BITS-1:0] fetch_y,
   output logic [GRP_BITS-1:0] fetch_grp,
   input  logic                fetch_ack,
   output logic                mac_start,
   output logic                mac_clear,
   input  logic                mac_res_valid,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [DIM_BITS-1:0] wr_x,
   output logic [DIM_BITS-1:0] wr_y,
   output logic [GRP_BITS-1:0] wr_grp
);

   if (NUM_MACS < 1) begin : g_num_macs_check
      $error("conv_tile_scheduler: NUM_MACS must be at least 1");
   end

   localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);
   localparam logic [GRP_BITS-1:0] GRP_ONE = GRP_BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state;
   logic [DIM_BITS-1:0] x;
   logic [DIM_BITS-1:0] y;
   logic [GRP_BITS-1:0] grp;
   logic [DIM_BITS-1:0] w_q;
   logic [DIM_BITS-1:0] h_q;
   logic [GRP_BITS-1:0] last_grp_q;
   logic                mode_q;

   logic at_last_grp;
   logic at_last_x;
   logic at_last_y;

   assign at_last_grp = (grp == last_grp_q);
   assign at_last_x   = (x == w_q - DIM_ONE);
   assign at_last_y   = (y == h_q - DIM_ONE);

   // Coordinates come straight from the loop counters, which only move on a handshake,
   // so they are stable for as long as a request is pending.
   assign fetch_x   = x;
   assign fetch_y   = y;
   assign fetch_grp = grp;
   assign wr_x      = x;
   assign wr_y      = y;
   assign wr_grp    = mode_q ? grp : '0;

   // NOTE: all state and registered outputs use non-blocking assignments so every branch
   // below sees the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         x          <= '0;
         y          <= '0;
         grp        <= '0;
         w_q        <= '0;
         h_q        <= '0;
         last_grp_q <= '0;
         mode_q     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fetch_req  <= 1'b0;
         mac_start  <= 1'b0;
         mac_clear  <= 1'b0;
         wr_valid   <= 1'b0;
      end else begin
         done      <= 1'b0;
         mac_start <= 1'b0;
         mac_clear <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  w_q        <= cfg_out_w;
                  h_q        <= cfg_out_h;
                  last_grp_q <= (cfg_groups == '0) ? '0 : cfg_groups - GRP_ONE;
                  mode_q     <= cfg_mode;
                  x          <= '0;
                  y          <= '0;
                  grp        <= '0;
                  busy       <= 1'b1;
                  if (cfg_out_w == '0 || cfg_out_h == '0) begin
                     state <= S_DONE;
                  end else begin
                     fetch_req <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (fetch_ack) begin
                  fetch_req <= 1'b0;
                  mac_start <= 1'b1;
                  mac_clear <= (grp == '0) || mode_q;
                  state     <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (mac_res_valid) begin
                  if (mode_q || at_last_grp) begin
                     wr_valid <= 1'b1;
                     state    <= S_WRITE;
                  end else begin
                     grp       <= grp + GRP_ONE;
                     fetch_req <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_WRITE: begin
               if (wr_ready) begin
                  wr_valid <= 1'b0;
                  if (mode_q && !at_last_grp) begin
                     grp <= grp + GRP_ONE;
                  end else begin
                     grp <= '0;
                     if (at_last_x) begin
                        x <= '0;
                        if (!at_last_y) y <= y + DIM_ONE;
                     end else begin
                        x <= x + DIM_ONE;
                     end
                  end
                  if (at_last_x && at_last_y && at_last_grp) begin
                     state <= S_DONE;
                  end else begin
                     fetch_req <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end

            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler: models the buffer, MAC array and output writer,
// and compares every fetch, issue and write against an expected raster walk.
module tb_conv_tile_scheduler;

   localparam int DB = 8;
   localparam int GB = 4;

   typedef struct packed {
      logic [DB-1:0] x;
      logic [DB-1:0] y;
      logic [GB-1:0] g;
   } coord_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DB-1:0] cfg_out_w;
   logic [DB-1:0] cfg_out_h;
   logic [GB-1:0] cfg_groups;
   logic          cfg_mode;
   logic          busy, done, fetch_req, mac_start, mac_clear, wr_valid;
   logic [DB-1:0] fetch_x, fetch_y, wr_x, wr_y;
   logic [GB-1:0] fetch_grp, wr_grp;
   logic          fetch_ack, mac_res_valid, wr_ready;

   int checks   = 0;
   int failures = 0;
   int ack_delay = 0;
   int mac_lat   = 2;
   int wr_stall  = 0;
   int n_wr      = 0;
   int n_done    = 0;
   int n_freq    = 0;
   int n_issue   = 0;

   coord_t exp_fetch[$];
   coord_t exp_wr[$];
   bit     exp_clear[$];

   conv_tile_scheduler #(.NUM_MACS(16), .DIM_BITS(DB), .GRP_BITS(GB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_groups(cfg_groups), .cfg_mode(cfg_mode),
      .busy(busy), .done(done),
      .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_grp(fetch_grp),
      .fetch_ack(fetch_ack),
      .mac_start(mac_start), .mac_clear(mac_clear), .mac_res_valid(mac_res_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_grp(wr_grp)
   );

   always #5 clk = ~clk;

   // Buffer, MAC array and writer models; sample on the falling edge, then drive responses.
   initial begin : responder
      int fcnt, wcnt, mcnt;
      coord_t prev_f, prev_w, got, exp_c;
      bit     exp_b;
      fcnt = 0; wcnt = 0; mcnt = 0;
      prev_f = '0; prev_w = '0;
      fetch_ack = 1'b0; wr_ready = 1'b0; mac_res_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            fetch_ack = 1'b0; wr_ready = 1'b0; mac_res_valid = 1'b0;
            fcnt = 0; wcnt = 0; mcnt = 0;
         end else begin
            if (done) n_done++;

            if (fetch_req) begin
               n_freq++;
               got = {fetch_x, fetch_y, fetch_grp};
               if (fcnt > 0) begin
                  checks++;
                  if (got !== prev_f) begin
                     failures++;
                     $display("FAIL fetch_stable: got %h while pending, required %h", got, prev_f);
                  end
               end
               prev_f = got;
               if (fcnt >= ack_delay) begin
                  fetch_ack = 1'b1;
                  checks++;
                  if (exp_fetch.size() == 0) begin
                     failures++;
                     $display("FAIL fetch_order: unexpected fetch %h, none required", got);
                  end else begin
                     exp_c = exp_fetch.pop_front();
                     if (got !== exp_c) begin
                        failures++;
                        $display("FAIL fetch_order: got %h required %h", got, exp_c);
                     end
                  end
               end else begin
                  fetch_ack = 1'b0;
               end
               fcnt++;
            end else begin
               fetch_ack = 1'b0;
               fcnt = 0;
            end

            mac_res_valid = 1'b0;
            if (mac_start) begin
               n_issue++;
               checks++;
               if (exp_clear.size() == 0) begin
                  failures++;
                  $display("FAIL mac_issue: unexpected mac_start, none required");
               end else begin
                  exp_b = exp_clear.pop_front();
                  if (mac_clear !== exp_b) begin
                     failures++;
                     $display("FAIL mac_clear: got %b required %b", mac_clear, exp_b);
                  end
               end
               mcnt = mac_lat;
            end else if (mcnt > 0) begin
               mcnt--;
               if (mcnt == 0) mac_res_valid = 1'b1;
            end

            if (wr_valid) begin
               got = {wr_x, wr_y, wr_grp};
               if (wcnt > 0) begin
                  checks++;
                  if (got !== prev_w) begin
                     failures++;
                     $display("FAIL wr_stable: got %h while pending, required %h", got, prev_w);
                  end
               end
               prev_w = got;
               if (wcnt >= wr_stall) begin
                  wr_ready = 1'b1;
                  n_wr++;
                  checks++;
                  if (exp_wr.size() == 0) begin
                     failures++;
                     $display("FAIL wr_order: unexpected write %h, none required", got);
                  end else begin
                     exp_c = exp_wr.pop_front();
                     if (got !== exp_c) begin
                        failures++;
                        $display("FAIL wr_order: got %h required %h", got, exp_c);
                     end
                  end
               end else begin
                  wr_ready = 1'b0;
               end
               wcnt++;
            end else begin
               wr_ready = 1'b0;
               wcnt = 0;
            end
         end
      end
   end

   // Expected raster walk: group innermost, then x, then y.
   task automatic push_layer(input int w, input int h, input int g, input bit mode);
      int gg;
      gg = (g == 0) ? 1 : g;
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++) begin
            for (int gr = 0; gr < gg; gr++) begin
               exp_fetch.push_back({DB'(xx), DB'(yy), GB'(gr)});
               exp_clear.push_back((gr == 0) || mode);
               if (mode) exp_wr.push_back({DB'(xx), DB'(yy), GB'(gr)});
            end
            if (!mode) exp_wr.push_back({DB'(xx), DB'(yy), GB'(0)});
         end
   endtask

   task automatic pulse_start(input int w, input int h, input int g, input bit mode);
      @(negedge clk);
      cfg_out_w = DB'(w); cfg_out_h = DB'(h); cfg_groups = GB'(g); cfg_mode = mode;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout: done not seen, required within 3000 cycles", name);
      end
   endtask

   task automatic finish_layer(input string name, input int done0, input int wr0, input int wr_req);
      wait_done(name);
      repeat (4) @(negedge clk);
      checks++;
      if (n_done - done0 !== 1) begin
         failures++;
         $display("FAIL %s_done_count: got %0d required 1", name, n_done - done0);
      end
      checks++;
      if (n_wr - wr0 !== wr_req) begin
         failures++;
         $display("FAIL %s_write_count: got %0d required %0d", name, n_wr - wr0, wr_req);
      end
      checks++;
      if (exp_fetch.size() + exp_wr.size() + exp_clear.size() !== 0) begin
         failures++;
         $display("FAIL %s_leftover: %0d fetch %0d write %0d issue expectations unmet, required 0",
                  name, exp_fetch.size(), exp_wr.size(), exp_clear.size());
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle_busy: got %b required 0", name, busy);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({busy, done, fetch_req, mac_start, mac_clear, wr_valid} !== 6'b0 ||
          {fetch_x, fetch_y, fetch_grp, wr_x, wr_y, wr_grp} !== '0) begin
         failures++;
         $display("FAIL %s: got ctrl=%b fetch=%h/%h/%h wr=%h/%h/%h required all 0", name,
                  {busy, done, fetch_req, mac_start, mac_clear, wr_valid},
                  fetch_x, fetch_y, fetch_grp, wr_x, wr_y, wr_grp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0;
      cfg_out_w = '0; cfg_out_h = '0; cfg_groups = '0; cfg_mode = 1'b0;
      #12;
      check_outputs_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_mode0_2x2();
      int d0, w0;
      d0 = n_done; w0 = n_wr;
      ack_delay = 0; mac_lat = 2; wr_stall = 0;
      push_layer(2, 2, 1, 1'b0);
      pulse_start(2, 2, 1, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mode0_2x2_busy: got %b required 1", busy);
      end
      finish_layer("mode0_2x2", d0, w0, 4);
   endtask

   task automatic test_mode0_groups();
      int d0, w0;
      d0 = n_done; w0 = n_wr;
      ack_delay = 0; mac_lat = 1; wr_stall = 0;
      push_layer(1, 1, 3, 1'b0);
      pulse_start(1, 1, 3, 1'b0);
      finish_layer("mode0_groups", d0, w0, 1);
      d0 = n_done; w0 = n_wr;
      push_layer(2, 1, 0, 1'b0);
      pulse_start(2, 1, 0, 1'b0);
      finish_layer("groups_zero", d0, w0, 2);
   endtask

   task automatic test_mode1();
      int d0, w0;
      d0 = n_done; w0 = n_wr;
      ack_delay = 1; mac_lat = 3; wr_stall = 0;
      push_layer(1, 2, 2, 1'b1);
      pulse_start(1, 2, 2, 1'b1);
      finish_layer("mode1", d0, w0, 4);
   endtask

   task automatic test_back_to_back();
      int d0, w0;
      d0 = n_done; w0 = n_wr;
      ack_delay = 3; mac_lat = 2; wr_stall = 5;
      push_layer(2, 1, 2, 1'b1);
      pulse_start(2, 1, 2, 1'b1);
      finish_layer("backpressure", d0, w0, 4);
      d0 = n_done; w0 = n_wr;
      ack_delay = 2; wr_stall = 3;
      push_layer(3, 2, 2, 1'b0);
      pulse_start(3, 2, 2, 1'b0);
      finish_layer("backpressure_m0", d0, w0, 6);
      ack_delay = 0; wr_stall = 0;
   endtask

   task automatic test_empty_layer();
      int d0, w0, f0;
      d0 = n_done; w0 = n_wr; f0 = n_freq;
      @(negedge clk);
      cfg_out_w = '0; cfg_out_h = 8'd3; cfg_groups = 4'd1; cfg_mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL empty_cycle1: got done=%b busy=%b required done=0 busy=1", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL empty_cycle2: got done=%b busy=%b required done=1 busy=0", done, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (n_freq - f0 !== 0 || n_done - d0 !== 1 || n_wr - w0 !== 0) begin
         failures++;
         $display("FAIL empty_activity: got fetch=%0d done=%0d writes=%0d required 0/1/0",
                  n_freq - f0, n_done - d0, n_wr - w0);
      end

      d0 = n_done; w0 = n_wr;
      mac_lat = 6;
      push_layer(1, 1, 1, 1'b0);
      pulse_start(1, 1, 1, 1'b0);
      repeat (3) @(negedge clk);
      cfg_out_w = 8'd2; cfg_out_h = 8'd2; cfg_mode = 1'b1; cfg_groups = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_layer("start_while_busy", d0, w0, 1);
      mac_lat = 2;
   endtask

   task automatic test_reset_mid_layer();
      int d0, w0;
      bit in_wait;
      ack_delay = 0; mac_lat = 30; wr_stall = 0;
      push_layer(2, 1, 2, 1'b0);
      pulse_start(2, 1, 2, 1'b0);
      in_wait = 1'b0;
      for (int i = 0; i < 50 && !in_wait; i++) begin
         @(negedge clk);
         if (mac_start) in_wait = 1'b1;
      end
      checks++;
      if (!in_wait) begin
         failures++;
         $display("FAIL reset_mid_issue: got no mac_start required one within 50 cycles");
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("reset_mid_layer");
      exp_fetch.delete(); exp_wr.delete(); exp_clear.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mac_lat = 2;
      @(negedge clk);
      d0 = n_done; w0 = n_wr;
      push_layer(2, 1, 2, 1'b0);
      pulse_start(2, 1, 2, 1'b0);
      finish_layer("restart", d0, w0, 2);
   endtask

   initial begin
      test_reset();
      test_mode0_2x2();
      test_mode0_groups();
      test_mode1();
      test_back_to_back();
      test_empty_layer();
      test_reset_mid_layer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
